demosaic_sequencer: RTL and testbench
=====================================

Name: demosaic_sequencer

Overview:
Controller that sequences one full demosaic pass over a Bayer frame held in the input pixel memory. It walks the raster, issues 3x3-window read addresses, and carries the lateral/vertical/color tags aligned with the one-cycle-latency read data into the combinational 3x3 filter. It also drives writes of the filtered RGBA pixel into the output channel memory, with a ready/valid backpressure from that writer. Replaces the free-running address counter plus $finish with a start/busy/done handshake.

Parameters:
IMG_WIDTH, 40, pixels per row (>=2)
IMG_HEIGHT, 30, rows per frame (>=2)
ADDR_W, 11, address width; must satisfy 2**ADDR_W >= IMG_WIDTH*IMG_HEIGHT

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous active-low reset (0 = reset)
start  in  1  begin frame; sampled only in IDLE
abort  in  1  synchronous frame cancel; wins over everything except reset
cfg_bayer_phase  in  2  CFA phase, latched at start: bit0 xors x parity, bit1 xors y parity
rd_en  out  1  input-memory read strobe; memory holds its read data while rd_en=0
rd_addr  out  ADDR_W  centre-pixel address y*IMG_WIDTH+x
filt_lateral  out  lateral_t  tag for data currently on memory output
filt_vertical  out  vertical_t  tag for data currently on memory output
filt_color  out  color_t  tag for data currently on memory output
wr_en  out  1  valid: filter output is to be written at wr_addr
wr_addr  out  ADDR_W  output-memory address, aligned with filt_* tags
wr_ready  in  1  writer accepts; a write completes when wr_en && wr_ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last pixel's write completes

Behaviour:
- States: IDLE, RUN (issuing reads), DRAIN (all issued, last write pending).
- Reset (reset=0 at posedge): state IDLE; x=y=0; s1_valid=0; latched phase=0. Outputs: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, busy=0, done=0, filt_lateral=Center, filt_vertical=Middle, filt_color=Red.
- IDLE: start=1 -> RUN; x=y=0; latch cfg_bayer_phase. start=0 -> stay.
- Issue condition: issue = (state==RUN) && (!s1_valid || wr_ready). rd_en = issue (combinational). rd_addr = y*IMG_WIDTH+x (registered counters, combinational product/sum, ADDR_W bits).
- On issue: s1 captures addr and tags; s1_valid<=1. x increments; at x==IMG_WIDTH-1, x<=0 and y increments. Issuing (IMG_WIDTH-1, IMG_HEIGHT-1) -> DRAIN.
- No issue and wr_en&&wr_ready: s1_valid<=0. No issue and no handshake: s1 holds (stall). Read data stays valid because rd_en=0.
- Tags: lateral Left if x==0, Right if x==IMG_WIDTH-1, else Center. Vertical Top if y==0, Bottom if y==IMG_HEIGHT-1, else Middle.
- Color: idx={x[0]^p[0], y[0]^p[1]}: 00 Red, 11 Blue, 10 GreenBesideRed, 01 GreenBesideBlue.
- wr_en=s1_valid; wr_addr and filt_* come from s1 registers. Latency from issue to wr_en: 1 cycle.
- DRAIN: on wr_en&&wr_ready -> IDLE; done<=1 for exactly one cycle.
- With wr_ready=1 throughout, start sampled at edge 0 gives:
  - rd_en cycles 1..N (N=W*H)
  - wr_en cycles 2..N+1
  - done in cycle N+2
  - busy cycles 1..N+1
- start while busy: ignored; cfg_bayer_phase changes while busy: ignored.
- abort=1 at posedge with state!=IDLE: next cycle IDLE, s1_valid=0, wr_en=0, no done pulse. The in-flight write is dropped even if wr_ready=1 in that cycle.
- abort in IDLE: no effect; abort overrides a same-cycle start.
- Reset mid-frame behaves like abort plus full register clear.
- The filter is combinational between the memory output and the writer; the sequencer adds no pixel arithmetic.

Decomposition:
- demosaic_pkg holds: color_t, lateral_t, vertical_t (Top/Middle/Bottom), rgba_t, IMG_WIDTH/IMG_HEIGHT defaults, and sequencer state enum.
- One sub-module: raster_counter (x/y counters with advance enable, wrap, and first/last-column and first/last-row flags). The sequencer instantiates it.

Test Plan:
- Full frame, wr_ready=1, phase 0: 1200 writes with wr_addr 0..1199 in order. Done pulses once, in cycle 1202. Addr 0 tagged Left/Top/Red; addr 41 tagged Center/Middle/Blue; addr 1199 tagged Right/Bottom/Blue.
- phase=2'b01: addr 0 tagged GreenBesideRed, addr 1 tagged Red. A phase change after start does not alter tags.
- Random wr_ready (50%): no address is skipped or duplicated. While wr_en=1 && wr_ready=0, wr_addr/filt_* are stable and rd_en=0. Each write carries the memory data for its own address.
- abort at wr_addr=500 with wr_ready=0: next cycle busy=0, wr_en=0, no done. A new start restarts at addr 0.
- reset=0 for one cycle mid-frame: all outputs at reset values the next cycle. start during busy and abort in IDLE have no effect.
- 4x2 parameterisation: 8 writes; x=3 tagged Right; y=1 tagged Bottom; done in cycle 10.

Source files
------------

// File: rtl/demosaic_pkg.sv
// Shared types for the demosaic path: CFA colour, window-edge tags, RGBA pixel, sequencer states.
package demosaic_pkg;

  localparam int DEF_IMG_WIDTH  = 40;
  localparam int DEF_IMG_HEIGHT = 30;

  // Encoding equals {x parity, y parity} after the phase flip, so the lookup is a plain cast.
  typedef enum logic [1:0] {
    COLOR_RED        = 2'b00,
    COLOR_GREEN_BLUE = 2'b01,
    COLOR_GREEN_RED  = 2'b10,
    COLOR_BLUE       = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    LAT_LEFT   = 2'd0,
    LAT_CENTER = 2'd1,
    LAT_RIGHT  = 2'd2
  } lateral_t;

  typedef enum logic [1:0] {
    VERT_TOP    = 2'd0,
    VERT_MIDDLE = 2'd1,
    VERT_BOTTOM = 2'd2
  } vertical_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  function automatic color_t bayer_color(input logic x0, input logic y0, input logic [1:0] phase);
    return color_t'({x0 ^ phase[0], y0 ^ phase[1]});
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position with advance enable and row/column wrap; edge flags are combinational.
// Latency: position updates one cycle after advance; clear wins over advance.
module raster_counter #(
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 30,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          first_col,
  output logic          last_col,
  output logic          first_row,
  output logic          last_row
);

  assign first_col = (x == '0);
  assign last_col  = (x == XW'(WIDTH - 1));
  assign first_row = (y == '0);
  assign last_row  = (y == YW'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last_col) begin
        x <= '0;
        y <= last_row ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/demosaic_sequencer.sv
// Walks a Bayer frame issuing centre-pixel reads and tags; write stage trails the read by one cycle.
// Backpressure: a stalled write (wr_en && !wr_ready) blocks the next read so memory data stays put.
module demosaic_sequencer
  import demosaic_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        cfg_bayer_phase,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output lateral_t          filt_lateral,
  output vertical_t         filt_vertical,
  output color_t            filt_color,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  seq_state_t    state;
  logic [1:0]    phase;
  logic          s1_valid;
  logic          issue;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          first_col, last_col, first_row, last_row;
  lateral_t      lat_c;
  vertical_t     vert_c;

  raster_counter #(
    .WIDTH  (IMG_WIDTH),
    .HEIGHT (IMG_HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == ST_IDLE),
    .advance   (issue),
    .x         (x),
    .y         (y),
    .first_col (first_col),
    .last_col  (last_col),
    .first_row (first_row),
    .last_row  (last_row)
  );

  // A new read may only replace the s1 slot when it is empty or being drained this cycle.
  assign issue   = (state == ST_RUN) && (!s1_valid || wr_ready);
  assign rd_en   = issue;
  assign rd_addr = ADDR_W'(y) * ADDR_W'(IMG_WIDTH) + ADDR_W'(x);
  assign wr_en   = s1_valid;
  assign busy    = (state != ST_IDLE);

  assign lat_c  = first_col ? LAT_LEFT : (last_col ? LAT_RIGHT : LAT_CENTER);
  assign vert_c = first_row ? VERT_TOP : (last_row ? VERT_BOTTOM : VERT_MIDDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      phase         <= 2'b00;
      s1_valid      <= 1'b0;
      wr_addr       <= '0;
      filt_lateral  <= LAT_CENTER;
      filt_vertical <= VERT_MIDDLE;
      filt_color    <= COLOR_RED;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Cancels the frame and drops any pending write; in IDLE it just masks start.
        state    <= ST_IDLE;
        s1_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_RUN;
              phase <= cfg_bayer_phase;
            end
          end
          ST_RUN, ST_DRAIN: begin
            if (issue) begin
              s1_valid      <= 1'b1;
              wr_addr       <= rd_addr;
              filt_lateral  <= lat_c;
              filt_vertical <= vert_c;
              filt_color    <= bayer_color(x[0], y[0], phase);
              if (last_col && last_row) begin
                state <= ST_DRAIN;
              end
            end else if (s1_valid && wr_ready) begin
              s1_valid <= 1'b0;
              if (state == ST_DRAIN) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demosaic_sequencer.sv
// Directed bench: 40x30 sequencer against a modelled read memory, plus a 4x2 instance for edge tags.
module tb_demosaic_sequencer;
  import demosaic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, wr_ready;
  logic [1:0]  cfg;
  logic        rd_en, wr_en, busy, done;
  logic [10:0] rd_addr, wr_addr;
  lateral_t    lat;
  vertical_t   vert;
  color_t      col;

  logic        s_start, s_abort, s_wr_ready;
  logic [1:0]  s_cfg;
  logic        s_rd_en, s_wr_en, s_busy, s_done;
  logic [2:0]  s_rd_addr, s_wr_addr;
  lateral_t    s_lat;
  vertical_t   s_vert;
  color_t      s_col;

  int total = 0;
  int bad   = 0;

  logic [15:0] rd_data;

  demosaic_sequencer #(.IMG_WIDTH(40), .IMG_HEIGHT(30), .ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_bayer_phase(cfg),
    .rd_en(rd_en), .rd_addr(rd_addr), .filt_lateral(lat), .filt_vertical(vert),
    .filt_color(col), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ready(wr_ready),
    .busy(busy), .done(done)
  );

  demosaic_sequencer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .ADDR_W(3)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort), .cfg_bayer_phase(s_cfg),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .filt_lateral(s_lat), .filt_vertical(s_vert),
    .filt_color(s_col), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_ready(s_wr_ready),
    .busy(s_busy), .done(s_done)
  );

  function automatic logic [15:0] mem_val(input logic [10:0] a);
    return 16'(a) * 16'd13 + 16'd5;
  endfunction

  // Read memory with one-cycle latency that holds its output while rd_en is low.
  always @(posedge clk) if (rd_en) rd_data <= mem_val(rd_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a frame whose start was sampled on the previous edge; cycle 1 is the current cycle.
  task automatic run_frame(input bit rnd, input bit hold_start);
    int cyc, nwr, ndone, done_cyc, rd_cnt, rd_first, rd_last, wr_first, wr_last, extra;
    logic [31:0] exp_addr, st_addr, st_lat, st_vert, st_col;
    bit stalled;
    cyc = 1; nwr = 0; ndone = 0; done_cyc = 0; rd_cnt = 0; rd_first = 0; rd_last = 0;
    wr_first = 0; wr_last = 0; extra = 0; exp_addr = 0; stalled = 0;
    st_addr = 0; st_lat = 0; st_vert = 0; st_col = 0;
    while (cyc <= 4000 && ndone == 0) begin
      wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = hold_start && (cyc < 20);
      #1;
      if (stalled) begin
        chk("stall_wr_en", 32'(wr_en), 32'd1);
        chk("stall_addr", 32'(wr_addr), st_addr);
        chk("stall_lat", 32'(lat), st_lat);
        chk("stall_vert", 32'(vert), st_vert);
        chk("stall_col", 32'(col), st_col);
      end
      stalled = 0;
      if (rd_en) begin
        rd_cnt++;
        if (rd_first == 0) rd_first = cyc;
        rd_last = cyc;
      end
      if (wr_en && wr_ready) begin
        chk("wr_addr_seq", 32'(wr_addr), exp_addr);
        chk("wr_data", 32'(rd_data), 32'(mem_val(wr_addr)));
        if (wr_addr == 11'd0) begin
          chk("a0_lat", 32'(lat), 32'(LAT_LEFT));
          chk("a0_vert", 32'(vert), 32'(VERT_TOP));
          chk("a0_col", 32'(col), 32'(COLOR_RED));
        end
        if (wr_addr == 11'd41) begin
          chk("a41_lat", 32'(lat), 32'(LAT_CENTER));
          chk("a41_vert", 32'(vert), 32'(VERT_MIDDLE));
          chk("a41_col", 32'(col), 32'(COLOR_BLUE));
        end
        if (wr_addr == 11'd1199) begin
          chk("a1199_lat", 32'(lat), 32'(LAT_RIGHT));
          chk("a1199_vert", 32'(vert), 32'(VERT_BOTTOM));
          chk("a1199_col", 32'(col), 32'(COLOR_BLUE));
        end
        exp_addr++;
        nwr++;
        if (wr_first == 0) wr_first = cyc;
        wr_last = cyc;
      end
      if (wr_en && !wr_ready) begin
        chk("stall_rd_en", 32'(rd_en), 32'd0);
        stalled = 1;
        st_addr = 32'(wr_addr); st_lat = 32'(lat); st_vert = 32'(vert); st_col = 32'(col);
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      tick();
      cyc++;
    end
    start    = 1'b0;
    wr_ready = 1'b1;
    chk("n_writes", 32'(nwr), 32'd1200);
    chk("n_reads", 32'(rd_cnt), 32'd1200);
    chk("n_done", 32'(ndone), 32'd1);
    if (!rnd) begin
      chk("done_cycle", 32'(done_cyc), 32'd1202);
      chk("rd_first", 32'(rd_first), 32'd1);
      chk("rd_last", 32'(rd_last), 32'd1200);
      chk("wr_first", 32'(wr_first), 32'd2);
      chk("wr_last", 32'(wr_last), 32'd1201);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      if (done) extra++;
      tick();
    end
    chk("done_once", 32'(extra), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int nwr, ndone, dc, cyc;
    bit found;
    reset = 1'b0; start = 1'b0; abort = 1'b0; wr_ready = 1'b1; cfg = 2'b00;
    s_start = 1'b0; s_abort = 1'b0; s_wr_ready = 1'b1; s_cfg = 2'b00;
    tick();
    tick();
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lat", 32'(lat), 32'(LAT_CENTER));
    chk("rst_vert", 32'(vert), 32'(VERT_MIDDLE));
    chk("rst_col", 32'(col), 32'(COLOR_RED));
    reset = 1'b1;
    tick();

    // Full frame, always ready, phase 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(1'b0, 1'b0);

    // Phase 01 latched at start; a later change must not leak into the tags.
    cfg = 2'b01; start = 1'b1;
    tick();
    start = 1'b0; cfg = 2'b10;
    nwr = 0;
    for (int c = 0; c < 10 && nwr < 2; c++) begin
      #1;
      if (wr_en) begin
        chk("ph_addr", 32'(wr_addr), 32'(nwr));
        chk("ph_col", 32'(col), (nwr == 0) ? 32'(COLOR_GREEN_RED) : 32'(COLOR_RED));
        nwr++;
      end
      tick();
    end
    chk("ph_nwr", 32'(nwr), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0; cfg = 2'b00;
    chk("ph_abort_busy", 32'(busy), 32'd0);

    // Abort while the write of address 500 is stalled.
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 700 && !found; c++) begin
      #1;
      if (wr_en && wr_addr == 11'd500) found = 1;
      else tick();
    end
    chk("abort_reach_500", 32'(found), 32'd1);
    wr_ready = 1'b0; abort = 1'b1;
    #1;
    chk("abort_stall_rd", 32'(rd_en), 32'd0);
    tick();
    abort = 1'b0; wr_ready = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    ndone = 0;
    repeat (5) begin
      #1;
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Restart from address 0, then reset mid-frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("restart_rd_en", 32'(rd_en), 32'd1);
    chk("restart_rd_addr", 32'(rd_addr), 32'd0);
    tick();
    chk("restart_wr_en", 32'(wr_en), 32'd1);
    chk("restart_wr_addr", 32'(wr_addr), 32'd0);
    repeat (48) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mrst_rd_en", 32'(rd_en), 32'd0);
    chk("mrst_rd_addr", 32'(rd_addr), 32'd0);
    chk("mrst_wr_en", 32'(wr_en), 32'd0);
    chk("mrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_lat", 32'(lat), 32'(LAT_CENTER));
    chk("mrst_vert", 32'(vert), 32'(VERT_MIDDLE));
    chk("mrst_col", 32'(col), 32'(COLOR_RED));
    tick();

    // Abort in IDLE does nothing and masks a same-cycle start.
    abort = 1'b1;
    tick();
    chk("idle_abort_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_start_rd_en", 32'(rd_en), 32'd0);
    tick();

    // Random backpressure, with start held high during the first cycles of the frame.
    start = 1'b1;
    tick();
    run_frame(1'b1, 1'b1);

    // 4x2 instance: edge tags and done timing.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    nwr = 0; dc = 0; cyc = 1;
    while (cyc <= 30 && dc == 0) begin
      #1;
      if (s_wr_en && s_wr_ready) begin
        chk("s_addr_seq", 32'(s_wr_addr), 32'(nwr));
        if (s_wr_addr == 3'd0) chk("s_a0_lat", 32'(s_lat), 32'(LAT_LEFT));
        if (s_wr_addr == 3'd3) begin
          chk("s_a3_lat", 32'(s_lat), 32'(LAT_RIGHT));
          chk("s_a3_vert", 32'(s_vert), 32'(VERT_TOP));
        end
        if (s_wr_addr == 3'd4) begin
          chk("s_a4_lat", 32'(s_lat), 32'(LAT_LEFT));
          chk("s_a4_vert", 32'(s_vert), 32'(VERT_BOTTOM));
          chk("s_a4_col", 32'(s_col), 32'(COLOR_GREEN_BLUE));
        end
        if (s_wr_addr == 3'd7) begin
          chk("s_a7_lat", 32'(s_lat), 32'(LAT_RIGHT));
          chk("s_a7_vert", 32'(s_vert), 32'(VERT_BOTTOM));
          chk("s_a7_col", 32'(s_col), 32'(COLOR_BLUE));
        end
        nwr++;
      end
      if (s_done) dc = cyc;
      tick();
      cyc++;
    end
    chk("s_n_writes", 32'(nwr), 32'd8);
    chk("s_done_cycle", 32'(dc), 32'd10);
    chk("s_busy_after", 32'(s_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
